// File: rtl/regfile_sb.sv
// Parametrised register file with per-register busy (scoreboard) bits, write-to-read
// bypass, a link-register write port and a registered jump-target output.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int LINK_REG = (1 << ADDR_W) - 1,
  parameter int PC_SHIFT = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NRD*ADDR_W-1:0]   RA,
  output logic [NRD*DATA_W-1:0]   RD,
  output logic [NRD-1:0]          RBUSY,
  input  logic                    WE,
  input  logic [ADDR_W-1:0]       WA,
  input  logic [DATA_W-1:0]       WD,
  input  logic                    ISSUE,
  input  logic [ADDR_W-1:0]       IA,
  input  logic                    LW,
  input  logic [DATA_W-1:0]       PCF,
  input  logic                    JR,
  input  logic [ADDR_W-1:0]       JA,
  output logic                    JSTALL,
  output logic [DATA_W-1:0]       PCJ,
  output logic                    JV
);

  localparam int                DEPTH  = 1 << ADDR_W;
  localparam int                NSRC   = NRD + 1;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_REG);
  localparam bit                ZR     = (ZERO_REG != 0);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] pcj_q, pcj_d;
  logic              jv_q, jv_d;

  logic [DATA_W-1:0] link_val;
  logic              wr_link, wr_main;

  // Source index NRD is the jump-register read; it shares the read-port rules.
  logic [ADDR_W-1:0] src_a [NSRC];
  logic [DATA_W-1:0] src_d [NSRC];
  logic [NSRC-1:0]   src_b;

  assign link_val = PCF + DATA_W'(1);
  assign wr_link  = LW & ~(ZR & (LINK_A == '0));
  assign wr_main  = WE & ~(ZR & (WA == '0)) & ~(LW & (WA == LINK_A));

  always_comb begin
    for (int unsigned i = 0; i < NRD; i++) begin
      src_a[i] = RA[i*ADDR_W +: ADDR_W];
    end
    src_a[NRD] = JA;
  end

  // Link data takes priority over WD when both target LINK_REG.
  always_comb begin
    src_b = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      src_d[i] = regs_q[src_a[i]];
      src_b[i] = busy_q[src_a[i]];
      if (wr_main && (WA == src_a[i])) begin
        src_d[i] = WD;
        src_b[i] = 1'b0;
      end
      if (wr_link && (LINK_A == src_a[i])) begin
        src_d[i] = link_val;
        src_b[i] = 1'b0;
      end
      if (ZR && (src_a[i] == '0)) begin
        src_d[i] = '0;
        src_b[i] = 1'b0;
      end
    end
  end

  always_comb begin
    RD    = '0;
    RBUSY = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      RD[i*DATA_W +: DATA_W] = src_d[i];
      RBUSY[i]               = src_b[i];
    end
  end

  assign JSTALL = JR & src_b[NRD];

  always_comb begin
    jv_d  = JR & ~src_b[NRD];
    pcj_d = pcj_q;
    if (jv_d) begin
      pcj_d = (JA == LINK_A) ? src_d[NRD] : (src_d[NRD] >> PC_SHIFT);
    end
  end

  // A new producer issuing on the same edge as a write-back keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      if ((WE && (WA == ADDR_W'(j))) || (LW && (LINK_A == ADDR_W'(j)))) begin
        busy_d[j] = 1'b0;
      end
      if (ISSUE && (IA == ADDR_W'(j)) && !(ZR && (j == 0))) begin
        busy_d[j] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        regs_q[j] <= '0;
      end
      busy_q <= '0;
      pcj_q  <= '0;
      jv_q   <= 1'b0;
    end else begin
      if (wr_main) begin
        regs_q[WA] <= WD;
      end
      if (wr_link) begin
        regs_q[LINK_A] <= link_val;
      end
      busy_q <= busy_d;
      pcj_q  <= pcj_d;
      jv_q   <= jv_d;
    end
  end

  assign PCJ = pcj_q;
  assign JV  = jv_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: default build plus a 4-port, 16-bit, 8-entry
// build with register 0 writable.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        a_rst, a_we, a_issue, a_lw, a_jr;
  logic [9:0]  a_ra;
  logic [4:0]  a_wa, a_ia, a_ja;
  logic [31:0] a_wd, a_pcf;
  logic [63:0] a_rd;
  logic [1:0]  a_rbusy;
  logic        a_jstall, a_jv;
  logic [31:0] a_pcj;

  // NRD=4, DATA_W=16, ADDR_W=3, ZERO_REG=0 instance
  logic        b_rst, b_we, b_issue, b_lw, b_jr;
  logic [11:0] b_ra;
  logic [2:0]  b_wa, b_ia, b_ja;
  logic [15:0] b_wd, b_pcf;
  logic [63:0] b_rd;
  logic [3:0]  b_rbusy;
  logic        b_jstall, b_jv;
  logic [15:0] b_pcj;

  regfile_sb u_a (
    .CLK(clk), .RESET(a_rst), .RA(a_ra), .RD(a_rd), .RBUSY(a_rbusy),
    .WE(a_we), .WA(a_wa), .WD(a_wd), .ISSUE(a_issue), .IA(a_ia),
    .LW(a_lw), .PCF(a_pcf), .JR(a_jr), .JA(a_ja), .JSTALL(a_jstall),
    .PCJ(a_pcj), .JV(a_jv)
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .NRD(4), .ZERO_REG(0)) u_b (
    .CLK(clk), .RESET(b_rst), .RA(b_ra), .RD(b_rd), .RBUSY(b_rbusy),
    .WE(b_we), .WA(b_wa), .WD(b_wd), .ISSUE(b_issue), .IA(b_ia),
    .LW(b_lw), .PCF(b_pcf), .JR(b_jr), .JA(b_ja), .JSTALL(b_jstall),
    .PCJ(b_pcj), .JV(b_jv)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [63:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_v(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_chk(input string tag, input logic [63:0] got);
    logic [63:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    chk(tag, got, e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a;
    a_we = 0; a_issue = 0; a_lw = 0; a_jr = 0;
    a_ra = '0; a_wa = '0; a_ia = '0; a_ja = '0; a_wd = '0; a_pcf = '0;
  endtask

  task automatic idle_b;
    b_we = 0; b_issue = 0; b_lw = 0; b_jr = 0;
    b_ra = '0; b_wa = '0; b_ia = '0; b_ja = '0; b_wd = '0; b_pcf = '0;
  endtask

  initial begin
    a_rst = 1; b_rst = 1;
    idle_a; idle_b;
    tick; tick;
    a_rst = 0; b_rst = 0;

    // reset state
    expect_v(64'd0); pop_chk("rst_pcj", 64'(a_pcj));
    expect_v(64'd0); pop_chk("rst_jv", 64'(a_jv));
    for (int a = 0; a < 32; a++) begin
      a_ra = {5'(a), 5'(a)};
      expect_v(64'd0); expect_v(64'd0);
      #1;
      pop_chk("rst_rd", a_rd);
      pop_chk("rst_rbusy", 64'(a_rbusy));
      tick;
    end

    // register 0 ignores writes
    a_we = 1; a_wa = 5'd0; a_wd = 32'hFFFF_FFFF; a_ra = '0;
    expect_v(64'd0); #1; pop_chk("zero_byp", 64'(a_rd[31:0]));
    tick; a_we = 0;
    expect_v(64'd0); #1; pop_chk("zero_store", 64'(a_rd[31:0]));

    // bypass then storage
    a_we = 1; a_wa = 5'd5; a_wd = 32'h1234_5678; a_ra = {5'd0, 5'd5};
    expect_v(64'h1234_5678); #1; pop_chk("byp_pre", 64'(a_rd[31:0]));
    tick; a_we = 0;
    expect_v(64'h1234_5678); #1; pop_chk("byp_post", 64'(a_rd[31:0]));

    // busy bits
    a_issue = 1; a_ia = 5'd7;
    tick; a_issue = 0; a_ra = {5'd7, 5'd5};
    expect_v(64'd1); #1; pop_chk("busy_set", 64'(a_rbusy[1]));
    a_we = 1; a_wa = 5'd7; a_wd = 32'hA5; a_issue = 1; a_ia = 5'd7;
    expect_v(64'd0); expect_v(64'hA5); #1;
    pop_chk("busy_byp", 64'(a_rbusy[1]));
    pop_chk("busy_rd", 64'(a_rd[63:32]));
    tick; a_we = 0; a_issue = 0;
    expect_v(64'd1); #1; pop_chk("busy_reissue", 64'(a_rbusy[1]));
    a_we = 1; a_wa = 5'd7; a_wd = 32'hA5;
    tick; a_we = 0;

    // link write beats WE to the link register
    a_lw = 1; a_pcf = 32'h100; a_we = 1; a_wa = 5'd31; a_wd = 32'hDEAD; a_ra = {5'd0, 5'd31};
    expect_v(64'h101); #1; pop_chk("link_byp", 64'(a_rd[31:0]));
    tick; a_lw = 0; a_we = 0;
    expect_v(64'h101); #1; pop_chk("link_store", 64'(a_rd[31:0]));
    a_jr = 1; a_ja = 5'd31;
    expect_v(64'd0); #1; pop_chk("jr31_stall", 64'(a_jstall));
    tick; a_jr = 0;
    expect_v(64'h101); expect_v(64'd1);
    pop_chk("jr31_pcj", 64'(a_pcj)); pop_chk("jr31_jv", 64'(a_jv));
    tick;
    expect_v(64'd0); expect_v(64'h101);
    pop_chk("jr31_jv_off", 64'(a_jv)); pop_chk("jr31_pcj_hold", 64'(a_pcj));
    a_lw = 1; a_pcf = 32'hFFFF_FFFF;
    tick; a_lw = 0;
    expect_v(64'd0); #1; pop_chk("link_wrap", 64'(a_rd[31:0]));

    // link and WE to different addresses both land
    a_lw = 1; a_pcf = 32'h10; a_we = 1; a_wa = 5'd3; a_wd = 32'h33;
    tick; a_lw = 0; a_we = 0; a_ra = {5'd3, 5'd31};
    expect_v({32'h33, 32'h11}); #1; pop_chk("dual_wr", a_rd);

    // link write clears busy on the link register
    a_issue = 1; a_ia = 5'd31;
    tick; a_issue = 0;
    expect_v(64'd1); #1; pop_chk("lbusy_set", 64'(a_rbusy));
    a_lw = 1; a_pcf = 32'h0;
    expect_v(64'd0); #1; pop_chk("lbusy_clr", 64'(a_rbusy));
    tick; a_lw = 0;
    expect_v(64'd0); #1; pop_chk("lbusy_after", 64'(a_rbusy));

    // shifted jump, stall, release by bypass
    a_we = 1; a_wa = 5'd9; a_wd = 32'h400;
    tick; a_we = 0; a_jr = 1; a_ja = 5'd9;
    tick; a_jr = 0;
    expect_v(64'h100); expect_v(64'd1);
    pop_chk("jr9_pcj", 64'(a_pcj)); pop_chk("jr9_jv", 64'(a_jv));
    a_issue = 1; a_ia = 5'd9;
    tick; a_issue = 0; a_jr = 1; a_ja = 5'd9;
    expect_v(64'd1); #1; pop_chk("jstall", 64'(a_jstall));
    tick;
    expect_v(64'd0); expect_v(64'h100); expect_v(64'd1);
    pop_chk("jstall_jv", 64'(a_jv)); pop_chk("jstall_pcj", 64'(a_pcj));
    pop_chk("jstall_held", 64'(a_jstall));
    a_we = 1; a_wa = 5'd9; a_wd = 32'h800;
    expect_v(64'd0); #1; pop_chk("jstall_byp", 64'(a_jstall));
    tick; a_we = 0; a_jr = 0;
    expect_v(64'h200); expect_v(64'd1);
    pop_chk("jbyp_pcj", 64'(a_pcj)); pop_chk("jbyp_jv", 64'(a_jv));

    // reset overrides concurrent traffic
    a_issue = 1; a_ia = 5'd12;
    tick;
    a_rst = 1; a_we = 1; a_wa = 5'd12; a_wd = 32'h77; a_issue = 1; a_ia = 5'd13;
    a_jr = 1; a_ja = 5'd5; a_lw = 1; a_pcf = 32'h5;
    tick; a_rst = 0; idle_a;
    expect_v(64'd0); expect_v(64'd0);
    pop_chk("rst2_pcj", 64'(a_pcj)); pop_chk("rst2_jv", 64'(a_jv));
    a_ra = {5'd12, 5'd5};
    expect_v(64'd0); expect_v(64'd0); #1;
    pop_chk("rst2_rd", a_rd); pop_chk("rst2_busy", 64'(a_rbusy));
    a_ra = {5'd13, 5'd31};
    expect_v(64'd0); expect_v(64'd0); #1;
    pop_chk("rst2_rd_b", a_rd); pop_chk("rst2_busy_b", 64'(a_rbusy));

    // second build: register 0 writable, four independent ports
    b_we = 1; b_wa = 3'd0; b_wd = 16'hBEEF; b_lw = 1; b_pcf = 16'h1233;
    b_ra = {3'd0, 3'd3, 3'd7, 3'd0};
    expect_v({16'hBEEF, 16'h0000, 16'h1234, 16'hBEEF}); #1; pop_chk("b_byp", b_rd);
    tick; idle_b;
    b_ra = {3'd3, 3'd0, 3'd0, 3'd7};
    expect_v({16'h0000, 16'hBEEF, 16'hBEEF, 16'h1234}); #1; pop_chk("b_store", b_rd);
    b_we = 1; b_wa = 3'd3; b_wd = 16'h0033; b_ra = {3'd3, 3'd7, 3'd0, 3'd3};
    expect_v({16'h0033, 16'h1234, 16'hBEEF, 16'h0033}); #1; pop_chk("b_byp3", b_rd);
    tick; idle_b;
    b_issue = 1; b_ia = 3'd0;
    tick; b_issue = 0;
    expect_v(64'hF); #1; pop_chk("b_busy0", 64'(b_rbusy));
    b_we = 1; b_wa = 3'd0; b_wd = 16'h0001;
    expect_v(64'd0); expect_v({4{16'h0001}}); #1;
    pop_chk("b_busy0_clr", 64'(b_rbusy)); pop_chk("b_rd0_byp", b_rd);
    tick; idle_b;
    b_jr = 1; b_ja = 3'd7;
    tick; b_jr = 0;
    expect_v(64'h1234); expect_v(64'd1);
    pop_chk("b_jlink_pcj", 64'(b_pcj)); pop_chk("b_jlink_jv", 64'(b_jv));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
